// File: rtl/pwm_peripheral.sv
// Sixteen-pin output stage: each pin is held low, driven high, or follows one shared
// 8-bit PWM waveform whose duty is latched only at period boundaries.
module pwm_peripheral #(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out
);

   localparam logic [7:0] PRESC_LAST = 8'(CLK_DIV - 1);

   logic [7:0]  presc_q, presc_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;
   logic [7:0]  duty_shadow_q, duty_shadow_d;
   logic [15:0] out_q, out_d;
   logic [15:0] en_out, en_pwm;
   logic        tick, wrap, pwm_raw;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   assign tick = (presc_q == PRESC_LAST);
   assign wrap = tick && (pwm_cnt_q == 8'hFF);

   always_comb begin
      presc_d       = tick ? 8'd0 : presc_q + 8'd1;
      pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      // Duty only moves at the period wrap so no runt pulse can be produced.
      duty_shadow_d = wrap ? pwm_duty_cycle : duty_shadow_q;
   end

   assign pwm_raw = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_pin
         assign out_d[gi] = en_out[gi] & (en_pwm[gi] ? pwm_raw : 1'b1);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q       <= 8'd0;
         pwm_cnt_q     <= 8'd0;
         duty_shadow_q <= 8'd0;
         out_q         <= 16'd0;
      end else begin
         presc_q       <= presc_d;
         pwm_cnt_q     <= pwm_cnt_d;
         duty_shadow_q <= duty_shadow_d;
         out_q         <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: point checks on out at chosen cycles and
// pulse-width/position checks on out[0], both queued by stimulus and popped by a monitor.
module tb_pwm_peripheral;

   localparam int PER = 3328;  // 256 * 13 clocks per PWM period

   logic        clk;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;

   pwm_peripheral #(.CLK_DIV(13)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out)
   );

   typedef struct {
      string       name;
      int          cyc;
      logic [15:0] mask;
      logic [15:0] val;
   } pt_t;

   typedef struct {
      string name;
      int    rise;
      int    width;
   } pl_t;

   pt_t pt_q[$];
   pl_t pl_q[$];
   int  cyc   = 0;
   int  total = 0;
   int  bad   = 0;
   bit  mon_en = 0;
   int  rel, rel2;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_pt(input string n, input int c, input logic [15:0] m, input logic [15:0] v);
      pt_t p;
      p.name = n; p.cyc = c; p.mask = m; p.val = v;
      pt_q.push_back(p);
   endtask

   task automatic push_pl(input string n, input int r, input int w);
      pl_t p;
      p.name = n; p.rise = r; p.width = w;
      pl_q.push_back(p);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: outputs are sampled on the falling edge, cyc = posedges seen so far.
   initial begin
      pt_t  p;
      pl_t  q;
      logic prev0     = 1'b0;
      bit   rise_seen = 0;
      int   rise_cyc  = 0;
      int   width;
      forever begin
         @(negedge clk);
         while (pt_q.size() > 0 && pt_q[0].cyc <= cyc) begin
            p = pt_q.pop_front();
            total++;
            if (p.cyc != cyc) begin
               bad++;
               $display("FAIL %s: slot cycle %0d not sampled, now at cycle %0d", p.name, p.cyc, cyc);
            end else if ((out & p.mask) !== p.val) begin
               bad++;
               $display("FAIL %s: cycle %0d out&%h=%h required %h", p.name, cyc, p.mask, out & p.mask, p.val);
            end else begin
               $display("point %s: cycle %0d out=%h ok", p.name, cyc, out);
            end
         end
         if (mon_en && out[0] === 1'b1 && prev0 === 1'b0) begin
            rise_seen = 1;
            rise_cyc  = cyc;
         end else if (out[0] === 1'b0 && prev0 === 1'b1 && rise_seen) begin
            rise_seen = 0;
            width     = cyc - rise_cyc;
            if (pl_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_pulse: rise %0d width %0d, required no pulse", rise_cyc, width);
            end else begin
               q = pl_q.pop_front();
               total += 2;
               if (rise_cyc != q.rise) begin
                  bad++;
                  $display("FAIL %s_rise: rise cycle %0d required %0d", q.name, rise_cyc, q.rise);
               end
               if (width != q.width) begin
                  bad++;
                  $display("FAIL %s_width: width %0d required %0d", q.name, width, q.width);
               end
               $display("pulse %s: rise %0d width %0d (required %0d/%0d)", q.name, rise_cyc, width, q.rise, q.width);
            end
         end
         prev0 = out[0];
      end
   end

   // Stimulus
   initial begin
      rst_n           = 1'b0;
      en_reg_out_7_0  = 8'hFF;
      en_reg_out_15_8 = 8'hFF;
      en_reg_pwm_7_0  = 8'hFF;
      en_reg_pwm_15_8 = 8'hFF;
      pwm_duty_cycle  = 8'hFF;

      push_pt("rst_hold_a", 1, 16'hFFFF, 16'h0000);
      push_pt("rst_hold_b", 2, 16'hFFFF, 16'h0000);
      wait_until(2);
      rst_n          = 1'b1;
      en_reg_pwm_7_0  = 8'h00;
      en_reg_pwm_15_8 = 8'h00;
      rel = cyc;
      push_pt("release_first_high", rel + 1, 16'hFFFF, 16'hFFFF);

      wait_until(rel + 2);
      en_reg_out_7_0  = 8'h01;
      en_reg_out_15_8 = 8'h00;
      pwm_duty_cycle  = 8'h00;
      push_pt("static_bit0_a", cyc + 1,  16'hFFFF, 16'h0001);
      push_pt("static_bit0_b", cyc + 15, 16'hFFFF, 16'h0001);
      push_pt("static_bit0_c", cyc + 60, 16'hFFFF, 16'h0001);

      wait_until(rel + 100);
      en_reg_out_7_0 = 8'hFF;
      en_reg_pwm_7_0 = 8'hFF;
      mon_en = 1;
      for (int j = 0; j <= 10; j++)
         push_pt("duty00_low", cyc + 1 + 1000 * j, 16'hFFFF, 16'h0000);

      // Duty FF is latched at the 4th wrap, edge rel+4*PER.
      wait_until(rel + 10200);
      pwm_duty_cycle = 8'hFF;
      push_pt("ff_before_wrap", rel + 4 * PER,     16'hFFFF, 16'h0000);
      push_pt("ff_after_wrap",  rel + 4 * PER + 1, 16'hFFFF, 16'h00FF);
      for (int j = 1; j <= 10; j++)
         push_pt("dutyff_high", rel + 4 * PER + 1 + 1000 * j, 16'hFFFF, 16'h00FF);

      wait_until(rel + 23400);
      pwm_duty_cycle = 8'h80;
      push_pl("ff_to_80", rel + 4 * PER + 1, 14976);
      push_pl("d80_a", rel + 9 * PER + 1, 1664);
      push_pt("d80_upper_low", rel + 9 * PER + 800, 16'hFFFF, 16'h00FF);
      push_pl("d80_b", rel + 10 * PER + 1, 1664);

      wait_until(rel + 34000);
      pwm_duty_cycle = 8'h40;
      push_pl("d40", rel + 11 * PER + 1, 832);

      wait_until(rel + 37000);
      pwm_duty_cycle = 8'hC0;
      push_pl("dC0", rel + 12 * PER + 1, 2496);

      wait_until(rel + 41000);
      en_reg_pwm_15_8 = 8'hFF;
      push_pt("pwm_without_en_hi", cyc + 1,    16'hFFFF, 16'h00FF);
      push_pt("pwm_without_en_lo", cyc + 1500, 16'hFF00, 16'h0000);
      push_pt("pulse_before_rst",  rel + 43300, 16'hFFFF, 16'h00FF);

      wait_until(rel + 44000);
      rst_n = 1'b0;
      push_pt("rst_mid_a", cyc + 1, 16'hFFFF, 16'h0000);
      push_pt("rst_mid_b", cyc + 2, 16'hFFFF, 16'h0000);
      push_pl("rst_cut", rel + 13 * PER + 1, 736);
      wait_until(cyc + 2);
      rst_n = 1'b1;
      rel2 = cyc;
      push_pt("post_rst_shadow0", rel2 + 1000,    16'hFFFF, 16'h0000);
      push_pt("restart_edge_lo",  rel2 + PER,     16'hFFFF, 16'h0000);
      push_pt("restart_edge_hi",  rel2 + PER + 1, 16'hFFFF, 16'h00FF);
      push_pl("restart_a", rel2 + PER + 1, 2496);
      push_pl("restart_b", rel2 + 2 * PER + 1, 2496);

      wait_until(rel2 + 2 * PER + 2496 + 100);
      total++;
      if (pt_q.size() != 0) begin
         bad++;
         $display("FAIL point_queue_drain: %0d pending, required 0", pt_q.size());
      end
      total++;
      if (pl_q.size() != 0) begin
         bad++;
         $display("FAIL pulse_queue_drain: %0d pending, required 0", pl_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: cycle %0d reached time limit, required finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
